// File: rtl/vector_recorder.sv
// vector_recorder: armed/triggered capture of the observed vector {a,b,c,y}
// into a DEPTH-word memory, with single-cycle registered readback while idle
// or done. Capture stops on stop, or when the last word is written.
module vector_recorder #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          trig,
    input  logic          stop,
    input  logic          a,
    input  logic          b,
    input  logic          c,
    input  logic          y,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] COUNT_LAST = (AW + 1)'(DEPTH - 1);

    state_t     state;
    logic [3:0] mem [DEPTH];
    logic [3:0] sample;
    logic       wr_en;
    logic       rd_ok;

    assign sample = {a, b, c, y};

    // A word is stored on the trigger edge in ARMED and on every CAPTURE edge,
    // unless stop wins or reset is holding the block.
    assign wr_en = !reset && !stop &&
                   (((state == ARMED) && trig) || (state == CAPTURE));

    // Readback is only served while no capture can be modifying the memory.
    assign rd_ok = rd_en && ((state == IDLE) || (state == DONE));

    // Status flags are pure decodes of the registers.
    assign busy = (state == ARMED) || (state == CAPTURE);
    assign done = (state == DONE);
    assign full = (count == COUNT_FULL);

    // Control FSM and capture counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (stop) begin
                        state <= DONE;
                    end else if (trig) begin
                        count <= (AW + 1)'(1);
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop) begin
                        state <= DONE;
                    end else begin
                        count <= count + (AW + 1)'(1);
                        if (count == COUNT_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        count <= '0;
                        state <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture memory write port; the write index is the current word count.
    // NOTE: the memory has no reset so it maps onto RAM and keeps its contents
    // across reset; wr_en already excludes writes while reset is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= sample;
        end
    end

    // Registered readback; addresses at or beyond count read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= 4'b0000;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                if ({1'b0, rd_addr} < count) begin
                    rd_data <= mem[rd_addr];
                end else begin
                    rd_data <= 4'b0000;
                end
            end
        end
    end

endmodule

// File: doc/vector_recorder.md
VECTOR_RECORDER -- requirements
Module: vector_recorder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving capture memory depth in words; power of two, at least 2.
REQ-002 The block SHALL have derived parameter AW, default $clog2(DEPTH), giving the read address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port arm, input, 1 bit: arm request from IDLE or DONE.
REQ-006 The block SHALL have port trig, input, 1 bit: capture trigger, honoured only in ARMED.
REQ-007 The block SHALL have port stop, input, 1 bit: early termination, honoured in ARMED or CAPTURE.
REQ-008 The block SHALL have ports a, b, c, input, 1 bit each: observed DUT inputs.
REQ-009 The block SHALL have port y, input, 1 bit: observed DUT output.
REQ-010 The block SHALL have port rd_en, input, 1 bit: readback request.
REQ-011 The block SHALL have port rd_addr, input, AW bits: readback word index.
REQ-012 The block SHALL have port rd_data, output, 4 bits: registered readback word {a,b,c,y}.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: rd_data valid this cycle.
REQ-014 The block SHALL have port count, output, AW+1 bits: number of words captured.
REQ-015 The block SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-016 The block SHALL have port busy, output, 1 bit: state is ARMED or CAPTURE.
REQ-017 The block SHALL have port done, output, 1 bit: state is DONE.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, ARMED, CAPTURE and DONE.
REQ-019 In IDLE, arm=1 SHALL move the FSM to ARMED on the next edge; all other inputs are ignored.
REQ-020 In ARMED with stop=0 and trig=1, the block SHALL write {a,b,c,y} to mem[0], set count=1 and enter CAPTURE on that edge.
REQ-021 In CAPTURE with stop=0, each edge SHALL write {a,b,c,y} to mem[count] and increment count by 1.
REQ-022 When the write into mem[DEPTH-1] occurs, the FSM SHALL enter DONE with count=DEPTH and full=1 on the same edge; no wrap-around and no further writes occur.
REQ-023 stop=1 in ARMED or CAPTURE SHALL enter DONE on the next edge with no write that cycle; stop takes priority over trig.
REQ-024 In DONE, arm=1 SHALL clear count to 0, clear full and enter ARMED; memory contents are retained.
REQ-025 arm SHALL be ignored in ARMED and CAPTURE.
REQ-026 Readback SHALL be served only in IDLE and DONE: rd_en=1 at edge N gives rd_data and rd_valid=1 at edge N+1 (1-cycle latency).
REQ-027 rd_valid SHALL be 1 for exactly one cycle per accepted rd_en; back-to-back reads give one word per cycle.
REQ-028 A read with rd_addr >= count SHALL return rd_data=4'b0000 with rd_valid=1.
REQ-029 rd_en in ARMED or CAPTURE SHALL be ignored: rd_valid=0 and rd_data holds its previous value.
REQ-030 busy and done SHALL be decoded combinationally from the state register only.

Reset
REQ-031 reset=1 SHALL immediately, independent of clk, force state=IDLE, count=0, full=0, rd_data=4'b0000 and rd_valid=0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 A reset asserted mid-CAPTURE SHALL abort the capture with no partial write completing after assertion.

Verification
REQ-034 Reset, arm, trig with {a,b,c,y}=0001, then 0100 and 1010 on the next edges, then stop: the block SHALL end in DONE with count=3, and reads of addr 0,1,2 SHALL return 0001, 0100, 1010 one cycle after each request.
REQ-035 Arm, trig, and hold trig low for DEPTH+4 cycles: count SHALL reach 16, full=1 and done=1 on the 16th write edge, with no further writes afterward.
REQ-036 In ARMED, assert stop=1 and trig=1 together: the block SHALL enter DONE with count=0, and a read of addr 0 SHALL return 0000.
REQ-037 Assert rd_en during CAPTURE: rd_valid SHALL stay 0; after DONE, read addr 5 with count=3: rd_data=0000 and rd_valid=1.
REQ-038 Assert reset between clock edges at count=7 in CAPTURE: state SHALL go to IDLE and count to 0 immediately; arm then trig SHALL restart the capture at mem[0].
REQ-039 From DONE, re-arm and capture 2 words: count SHALL be 2, and addr 2 SHALL return 0000 even though old data remains in memory.
